// File: rtl/shadow_ret_checker.sv
// Shadow return-address stack checker: calls push link addresses, returns pop and compare.
// Define SHADOW_RET_UNDERFLOW_CRASH_EN to make a return on an empty stack raise the alarm.
module shadow_ret_checker #(
    parameter int DEPTH = 8,
    parameter int VLEN  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  logic                     is_call_i,
    input  logic                     is_ret_i,
    input  logic [VLEN-1:0]          link_addr_i,
    input  logic [VLEN-1:0]          target_i,
    input  logic                     crash_ack_i,
    output logic                     crash_o,
    output logic [VLEN-1:0]          bad_target_o,
    output logic [$clog2(DEPTH):0]   depth_o,
    output logic                     overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = PW + 1;
    localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);

    typedef enum logic {
        MONITOR = 1'b0,
        ALARM   = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            crash_q, crash_d;
    logic            ovf_q, ovf_d;
    logic [VLEN-1:0] bad_q, bad_d;

    logic [VLEN-1:0] mem_q [DEPTH];

    logic [PW-1:0]   top_idx;
    logic [PW-1:0]   ptr_pop;
    logic [DW-1:0]   depth_pop;
    logic            event_ok;
    logic            mismatch;
    logic            mem_we;
    logic [PW-1:0]   mem_waddr;

    // ptr_q points at the next free slot; the youngest entry sits one below it.
    assign top_idx = ptr_q - PW'(1);

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        depth_d   = depth_q;
        crash_d   = crash_q;
        ovf_d     = ovf_q;
        bad_d     = bad_q;
        ptr_pop   = ptr_q;
        depth_pop = depth_q;
        mismatch  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;

        event_ok = (state_q == MONITOR) && valid_i && !flush_i;

        // Pop-and-compare happens before the push so a combined event reuses the freed slot.
        if (event_ok && is_ret_i) begin
            if (depth_q != '0) begin
                mismatch  = (mem_q[top_idx] != target_i);
                ptr_pop   = top_idx;
                depth_pop = depth_q - DW'(1);
            end
`ifdef SHADOW_RET_UNDERFLOW_CRASH_EN
            else begin
                mismatch = 1'b1;
            end
`endif
        end

        ptr_d   = ptr_pop;
        depth_d = depth_pop;

        if (event_ok && is_call_i) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_pop;
            ptr_d     = ptr_pop + PW'(1);
            if (depth_pop == DEPTH_FULL) begin
                ovf_d = 1'b1;
            end else begin
                depth_d = depth_pop + DW'(1);
            end
        end

        if (mismatch) begin
            state_d = ALARM;
            crash_d = 1'b1;
            bad_d   = target_i;
        end

        if (state_q == ALARM && crash_ack_i) begin
            state_d = MONITOR;
            crash_d = 1'b0;
            ptr_d   = '0;
            depth_d = '0;
        end

        // Flush only empties the stack; alarm and overflow history survive it.
        if (flush_i) begin
            ptr_d   = '0;
            depth_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= MONITOR;
            ptr_q   <= '0;
            depth_q <= '0;
            crash_q <= 1'b0;
            ovf_q   <= 1'b0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            crash_q <= crash_d;
            ovf_q   <= ovf_d;
            bad_q   <= bad_d;
        end
    end

    // NOTE: the entry array has no reset; depth_q guarantees stale entries are never compared.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= link_addr_i;
        end
    end

    assign crash_o      = crash_q;
    assign bad_target_o = bad_q;
    assign depth_o      = depth_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_shadow_ret_checker.sv
// Directed bench for shadow_ret_checker (DEPTH=8, VLEN=32); honours SHADOW_RET_UNDERFLOW_CRASH_EN.
module tb_shadow_ret_checker;

`ifdef SHADOW_RET_UNDERFLOW_CRASH_EN
    localparam bit UF = 1'b1;
`else
    localparam bit UF = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic        is_call_i;
    logic        is_ret_i;
    logic [31:0] link_addr_i;
    logic [31:0] target_i;
    logic        crash_ack_i;
    logic        crash_o;
    logic [31:0] bad_target_o;
    logic [3:0]  depth_o;
    logic        overflow_o;

    int passed = 0;
    int total  = 0;

    shadow_ret_checker #(.DEPTH(8), .VLEN(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .is_call_i    (is_call_i),
        .is_ret_i     (is_ret_i),
        .link_addr_i  (link_addr_i),
        .target_i     (target_i),
        .crash_ack_i  (crash_ack_i),
        .crash_o      (crash_o),
        .bad_target_o (bad_target_o),
        .depth_o      (depth_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ev(input logic c, input logic r, input logic [31:0] l, input logic [31:0] t);
        valid_i = 1'b1; is_call_i = c; is_ret_i = r; link_addr_i = l; target_i = t;
        tick();
        valid_i = 1'b0; is_call_i = 1'b0; is_ret_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (depth_o !== 4'd0) $display("FAIL reset_depth: got %0d want 0", depth_o); else passed++;
        total++; if (crash_o !== 1'b0) $display("FAIL reset_crash: got %b want 0", crash_o); else passed++;
        total++; if (overflow_o !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow_o); else passed++;
        total++; if (bad_target_o !== 32'h0) $display("FAIL reset_bad: got %h want 0", bad_target_o); else passed++;
    endtask

    task automatic test_match();
        do_reset();
        ev(1'b1, 1'b0, 32'h8000_0104, 32'h0);
        total++; if (depth_o !== 4'd1) $display("FAIL match_push_depth: got %0d want 1", depth_o); else passed++;
        ev(1'b0, 1'b1, 32'h0, 32'h8000_0104);
        total++; if (depth_o !== 4'd0) $display("FAIL match_pop_depth: got %0d want 0", depth_o); else passed++;
        total++; if (crash_o !== 1'b0) $display("FAIL match_crash: got %b want 0", crash_o); else passed++;
        tick();
        total++; if (crash_o !== 1'b0) $display("FAIL match_crash_later: got %b want 0", crash_o); else passed++;
    endtask

    task automatic test_mismatch();
        do_reset();
        ev(1'b1, 1'b0, 32'h8000_0000, 32'h0);
        ev(1'b1, 1'b0, 32'h8000_0104, 32'h0);
        ev(1'b0, 1'b1, 32'h0, 32'h8000_0200);
        total++; if (crash_o !== 1'b1) $display("FAIL mis_crash: got %b want 1", crash_o); else passed++;
        total++; if (bad_target_o !== 32'h8000_0200) $display("FAIL mis_bad: got %h want 80000200", bad_target_o); else passed++;
        total++; if (depth_o !== 4'd1) $display("FAIL mis_depth: got %0d want 1", depth_o); else passed++;
        ev(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        total++; if (depth_o !== 4'd1) $display("FAIL mis_frozen_depth: got %0d want 1", depth_o); else passed++;
        total++; if (crash_o !== 1'b1) $display("FAIL mis_held: got %b want 1", crash_o); else passed++;
        crash_ack_i = 1'b1;
        tick();
        crash_ack_i = 1'b0;
        total++; if (crash_o !== 1'b0) $display("FAIL mis_ack_crash: got %b want 0", crash_o); else passed++;
        total++; if (depth_o !== 4'd0) $display("FAIL mis_ack_depth: got %0d want 0", depth_o); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 8; i++) ev(1'b1, 1'b0, 32'(i * 32'h100), 32'h0);
        total++; if (depth_o !== 4'd8) $display("FAIL ovf_full_depth: got %0d want 8", depth_o); else passed++;
        total++; if (overflow_o !== 1'b0) $display("FAIL ovf_early: got %b want 0", overflow_o); else passed++;
        ev(1'b1, 1'b0, 32'h900, 32'h0);
        total++; if (overflow_o !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow_o); else passed++;
        total++; if (depth_o !== 4'd8) $display("FAIL ovf_depth: got %0d want 8", depth_o); else passed++;
        for (int i = 9; i >= 2; i--) begin
            ev(1'b0, 1'b1, 32'h0, 32'(i * 32'h100));
            total++; if (crash_o !== 1'b0) $display("FAIL ovf_ret_%0d: crash got %b want 0", i, crash_o); else passed++;
        end
        total++; if (depth_o !== 4'd0) $display("FAIL ovf_drained: got %0d want 0", depth_o); else passed++;
        ev(1'b0, 1'b1, 32'h0, 32'h100);
        total++; if (crash_o !== UF) $display("FAIL ovf_underflow: crash got %b want %b", crash_o, UF); else passed++;
        total++; if (depth_o !== 4'd0) $display("FAIL ovf_underflow_depth: got %0d want 0", depth_o); else passed++;
        crash_ack_i = 1'b1;
        tick();
        crash_ack_i = 1'b0;
        total++; if (overflow_o !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow_o); else passed++;
    endtask

    task automatic test_call_ret_same();
        do_reset();
        ev(1'b1, 1'b0, 32'h40, 32'h0);
        ev(1'b1, 1'b1, 32'h80, 32'h40);
        total++; if (crash_o !== 1'b0) $display("FAIL same_crash: got %b want 0", crash_o); else passed++;
        total++; if (depth_o !== 4'd1) $display("FAIL same_depth: got %0d want 1", depth_o); else passed++;
        ev(1'b0, 1'b1, 32'h0, 32'h80);
        total++; if (crash_o !== 1'b0) $display("FAIL same_next_ret: crash got %b want 0", crash_o); else passed++;
        total++; if (depth_o !== 4'd0) $display("FAIL same_next_depth: got %0d want 0", depth_o); else passed++;
        ev(1'b1, 1'b1, 32'h60, 32'h99);
        total++; if (depth_o !== 4'd1) $display("FAIL same_empty_depth: got %0d want 1", depth_o); else passed++;
        total++; if (crash_o !== UF) $display("FAIL same_empty_crash: got %b want %b", crash_o, UF); else passed++;
        crash_ack_i = 1'b1;
        tick();
        crash_ack_i = 1'b0;
        total++; if (depth_o !== (UF ? 4'd0 : 4'd1)) $display("FAIL same_after_ack: got %0d want %0d", depth_o, UF ? 0 : 1); else passed++;
    endtask

    task automatic test_flush_and_reset();
        do_reset();
        for (int i = 1; i <= 3; i++) ev(1'b1, 1'b0, 32'(i), 32'h0);
        total++; if (depth_o !== 4'd3) $display("FAIL flush_pre_depth: got %0d want 3", depth_o); else passed++;
        flush_i = 1'b1;
        ev(1'b1, 1'b0, 32'h44, 32'h0);
        flush_i = 1'b0;
        total++; if (depth_o !== 4'd0) $display("FAIL flush_depth: got %0d want 0", depth_o); else passed++;
        ev(1'b1, 1'b0, 32'h11, 32'h0);
        ev(1'b0, 1'b1, 32'h0, 32'h11);
        total++; if (crash_o !== 1'b0) $display("FAIL flush_ptr_reuse: crash got %b want 0", crash_o); else passed++;
        ev(1'b1, 1'b0, 32'h22, 32'h0);
        ev(1'b0, 1'b1, 32'h0, 32'h33);
        total++; if (crash_o !== 1'b1) $display("FAIL flush_mis_crash: got %b want 1", crash_o); else passed++;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        total++; if (crash_o !== 1'b1) $display("FAIL flush_keeps_alarm: got %b want 1", crash_o); else passed++;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        total++; if (crash_o !== 1'b0) $display("FAIL alarm_reset_crash: got %b want 0", crash_o); else passed++;
        total++; if (bad_target_o !== 32'h0) $display("FAIL alarm_reset_bad: got %h want 0", bad_target_o); else passed++;
        ev(1'b1, 1'b0, 32'h55, 32'h0);
        total++; if (depth_o !== 4'd1) $display("FAIL alarm_reset_monitor: got %0d want 1", depth_o); else passed++;
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; is_call_i = 1'b0; is_ret_i = 1'b0;
        link_addr_i = '0; target_i = '0; crash_ack_i = 1'b0;
        #2;
        test_reset();
        test_match();
        test_mismatch();
        test_overflow();
        test_call_ret_same();
        test_flush_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
